// File: rtl/led_sched_ctl.sv
// LED pattern scheduler: steps through a (mode, dwell) table written over the register write bus.
// Optional register readback is enabled by defining LED_SCHED_READBACK_EN.
module led_sched_ctl #(
    parameter int              DATA_W    = 8,
    parameter int              ADDR_W    = 4,
    parameter int              STEPS     = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(4'h4)
) (
    input  logic              xclk,
    input  logic              sys_rst,
    input  logic              wr_stb,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              tick,
`ifdef LED_SCHED_READBACK_EN
    input  logic [ADDR_W-1:0] rd_subaddr,
    output logic [DATA_W-1:0] rd_data,
`endif
    output logic [1:0]        mode,
    output logic              busy,
    output logic              done,
    output logic [2:0]        step_idx
);

    localparam int         CNT_W    = DATA_W - 2;
    localparam int         SKIP_W   = 4;
    localparam logic [1:0] MODE_OFF = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DWELL,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic                run_q, run_d;
    logic                loop_q, loop_d;
    logic [DATA_W-1:0]   entry_q [STEPS];
    logic [DATA_W-1:0]   entry_d [STEPS];
    logic [2:0]          idx_q, idx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [SKIP_W-1:0]   skip_q, skip_d;
    logic [1:0]          mode_q, mode_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                ctrl_wr;
    logic                restart;
    logic                tick_eff;
    logic [DATA_W-1:0]   cur_entry;
    logic [CNT_W-1:0]    cur_dwell;
    logic                idx_last;
    logic                adv_fin;
    logic [2:0]          adv_idx;
    logic [SKIP_W-1:0]   skip_inc;

    // A CTRL write wins over a coincident tick, so the tick is dropped.
    assign ctrl_wr   = wr_stb && (wr_addr == BASE_ADDR);
    assign run_d     = ctrl_wr ? wr_data[0] : run_q;
    assign loop_d    = ctrl_wr ? wr_data[1] : loop_q;
    assign restart   = ctrl_wr && wr_data[2];
    assign tick_eff  = tick && !ctrl_wr;

    assign idx_last  = (idx_q == 3'(STEPS - 1));
    assign adv_fin   = idx_last && !loop_d;
    assign adv_idx   = idx_last ? 3'd0 : idx_q + 3'd1;
    assign skip_inc  = skip_q + SKIP_W'(1);
    assign cur_dwell = cur_entry[DATA_W-1:2];

    always_comb begin
        cur_entry = '0;
        for (int i = 0; i < STEPS; i++) begin
            if (idx_q == 3'(i)) cur_entry = entry_q[i];
        end
    end

    always_comb begin
        for (int i = 0; i < STEPS; i++) begin
            entry_d[i] = entry_q[i];
            if (wr_stb && (wr_addr == BASE_ADDR + ADDR_W'(i + 1))) entry_d[i] = wr_data;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        skip_d  = skip_q;
        mode_d  = mode_q;
        busy_d  = 1'b0;
        done_d  = done_q;

        // Outputs follow the state occupied this cycle, so they lag the state by one clock.
        case (state_q)
            S_IDLE:  mode_d = MODE_OFF;
            S_LOAD: begin
                busy_d = 1'b1;
                if (cur_dwell != '0) mode_d = cur_entry[1:0];
            end
            S_DWELL: busy_d = 1'b1;
            S_DONE: begin
                mode_d = MODE_OFF;
                done_d = 1'b1;
            end
            default: ;
        endcase

        if (!run_d) begin
            state_d = S_IDLE;
        end else if (restart) begin
            state_d = S_LOAD;
            idx_d   = 3'd0;
            skip_d  = '0;
            done_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_LOAD;
                    idx_d   = 3'd0;
                    skip_d  = '0;
                    done_d  = 1'b0;
                end
                S_LOAD: begin
                    if (cur_dwell != '0) begin
                        cnt_d   = cur_dwell;
                        skip_d  = '0;
                        state_d = S_DWELL;
                    end else begin
                        // Counting consecutive skips stops an all-empty table from spinning.
                        skip_d = skip_inc;
                        if (skip_inc == SKIP_W'(STEPS)) begin
                            state_d = S_DONE;
                        end else if (adv_fin) begin
                            state_d = S_DONE;
                        end else begin
                            idx_d = adv_idx;
                        end
                    end
                end
                S_DWELL: begin
                    if (tick_eff) begin
                        if (cnt_q == CNT_W'(1)) begin
                            if (adv_fin) begin
                                state_d = S_DONE;
                            end else begin
                                state_d = S_LOAD;
                                idx_d   = adv_idx;
                            end
                        end else begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge xclk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_q <= S_IDLE;
            run_q   <= 1'b0;
            loop_q  <= 1'b0;
            idx_q   <= 3'd0;
            cnt_q   <= '0;
            skip_q  <= '0;
            mode_q  <= MODE_OFF;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < STEPS; i++) entry_q[i] <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            loop_q  <= loop_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            skip_q  <= skip_d;
            mode_q  <= mode_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            for (int i = 0; i < STEPS; i++) entry_q[i] <= entry_d[i];
        end
    end

    assign mode     = mode_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign step_idx = idx_q;

`ifdef LED_SCHED_READBACK_EN
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

    always_comb begin
        rd_data_d = '0;
        if (rd_subaddr == BASE_ADDR) begin
            rd_data_d = DATA_W'({busy_q, done_q, idx_q, loop_q, run_q});
        end
        for (int i = 0; i < STEPS; i++) begin
            if (rd_subaddr == BASE_ADDR + ADDR_W'(i + 1)) rd_data_d = entry_q[i];
        end
    end

    always_ff @(posedge xclk or negedge sys_rst) begin
        if (!sys_rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;
`endif

endmodule

// File: tb/tb_led_sched_ctl.sv
// Self-checking bench for led_sched_ctl: vector table, directed corner sequences, randomized run vs model.
module tb_led_sched_ctl;

    logic       xclk = 1'b0;
    logic       sys_rst = 1'b0;
    logic       wr_stb = 1'b0;
    logic [3:0] wr_addr = 4'h0;
    logic [7:0] wr_data = 8'h00;
    logic       tick = 1'b0;
    logic [1:0] mode;
    logic       busy;
    logic       done;
    logic [2:0] step_idx;
`ifdef LED_SCHED_READBACK_EN
    logic [3:0] rd_subaddr = 4'h0;
    logic [7:0] rd_data;
`endif

    int checks = 0;
    int errors = 0;

    led_sched_ctl dut (
        .xclk     (xclk),
        .sys_rst  (sys_rst),
        .wr_stb   (wr_stb),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .tick     (tick),
`ifdef LED_SCHED_READBACK_EN
        .rd_subaddr(rd_subaddr),
        .rd_data  (rd_data),
`endif
        .mode     (mode),
        .busy     (busy),
        .done     (done),
        .step_idx (step_idx)
    );

    always #5 xclk = ~xclk;

    // Reference model: phases of the sequencer and the values they present on the next clock.
    localparam int PH_IDLE = 0, PH_LOAD = 1, PH_DWELL = 2, PH_DONE = 3;
    bit         m_run, m_loop;
    logic [7:0] m_tab [4];
    int         m_ph, m_idx, m_cnt, m_skip;
    logic [1:0] m_mode;
    bit         m_busy, m_done;

    function automatic void model_reset();
        m_run = 0; m_loop = 0;
        for (int i = 0; i < 4; i++) m_tab[i] = 8'h00;
        m_ph = PH_IDLE; m_idx = 0; m_cnt = 0; m_skip = 0;
        m_mode = 2'b10; m_busy = 0; m_done = 0;
    endfunction

    function automatic void next_entry(input bit lp);
        if (m_idx < 3) begin
            m_idx = m_idx + 1; m_ph = PH_LOAD;
        end else if (lp) begin
            m_idx = 0; m_ph = PH_LOAD;
        end else begin
            m_ph = PH_DONE;
        end
    endfunction

    function automatic void model_step(input logic s, input logic [3:0] a, input logic [7:0] d, input logic t);
        bit ch, nrun, nloop, rs, tk;
        int dw;
        ch    = s && (a == 4'h4);
        nrun  = ch ? d[0] : m_run;
        nloop = ch ? d[1] : m_loop;
        rs    = ch && d[2];
        tk    = t && !ch;
        dw    = int'(m_tab[m_idx][7:2]);
        m_busy = (m_ph == PH_LOAD) || (m_ph == PH_DWELL);
        if (m_ph == PH_IDLE || m_ph == PH_DONE) m_mode = 2'b10;
        else if (m_ph == PH_LOAD && dw != 0) m_mode = m_tab[m_idx][1:0];
        if (m_ph == PH_DONE) m_done = 1;
        if (!nrun) begin
            m_ph = PH_IDLE;
        end else if (rs || m_ph == PH_IDLE) begin
            m_ph = PH_LOAD; m_idx = 0; m_skip = 0; m_done = 0;
        end else if (m_ph == PH_LOAD) begin
            if (dw != 0) begin
                m_cnt = dw; m_skip = 0; m_ph = PH_DWELL;
            end else begin
                m_skip = m_skip + 1;
                if (m_skip == 4) m_ph = PH_DONE;
                else next_entry(nloop);
            end
        end else if (m_ph == PH_DWELL && tk) begin
            m_cnt = m_cnt - 1;
            if (m_cnt == 0) next_entry(nloop);
        end
        m_run = nrun; m_loop = nloop;
        if (s && a >= 4'h5 && a <= 4'h8) m_tab[int'(a) - 5] = d;
    endfunction

    task automatic cyc(input logic s, input logic [3:0] a, input logic [7:0] d, input logic t);
        wr_stb = s; wr_addr = a; wr_data = d; tick = t;
        model_step(s, a, d, t);
        @(posedge xclk);
        #1;
        wr_stb = 1'b0; tick = 1'b0;
    endtask

    task automatic run_step(input int n);
        repeat (n) cyc(1'b0, 4'h0, 8'h00, 1'b1);
        cyc(1'b0, 4'h0, 8'h00, 1'b0);
    endtask

    task automatic check(input string name, input logic [1:0] em, input logic eb, input logic ed, input logic [2:0] ei);
        checks++;
        if ({mode, busy, done, step_idx} !== {em, eb, ed, ei}) begin
            errors++;
            $display("FAIL %s: got mode=%b busy=%b done=%b idx=%0d, expected mode=%b busy=%b done=%b idx=%0d",
                     name, mode, busy, done, step_idx, em, eb, ed, ei);
        end
    endtask

    task automatic check_model(input string name);
        check(name, m_mode, m_busy, m_done, 3'(m_idx));
    endtask

    typedef struct {
        logic       s;
        logic [3:0] a;
        logic [7:0] d;
        logic       t;
        logic [1:0] em;
        logic       eb;
        logic       ed;
        logic [2:0] ei;
    } vec_t;

    vec_t tbl [18];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Table (00,3),(01,2),(10,1),(00,1), loop=0: write, start, tick through to DONE.
        tbl[0]  = '{1'b1, 4'h5, 8'h0C, 1'b0, 2'b10, 1'b0, 1'b0, 3'd0};
        tbl[1]  = '{1'b1, 4'h6, 8'h09, 1'b0, 2'b10, 1'b0, 1'b0, 3'd0};
        tbl[2]  = '{1'b1, 4'h7, 8'h06, 1'b0, 2'b10, 1'b0, 1'b0, 3'd0};
        tbl[3]  = '{1'b1, 4'h8, 8'h04, 1'b0, 2'b10, 1'b0, 1'b0, 3'd0};
        tbl[4]  = '{1'b1, 4'h4, 8'h01, 1'b0, 2'b10, 1'b0, 1'b0, 3'd0};
        tbl[5]  = '{1'b0, 4'h0, 8'h00, 1'b0, 2'b00, 1'b1, 1'b0, 3'd0};
        tbl[6]  = '{1'b0, 4'h0, 8'h00, 1'b1, 2'b00, 1'b1, 1'b0, 3'd0};
        tbl[7]  = '{1'b0, 4'h0, 8'h00, 1'b1, 2'b00, 1'b1, 1'b0, 3'd0};
        tbl[8]  = '{1'b0, 4'h0, 8'h00, 1'b1, 2'b00, 1'b1, 1'b0, 3'd1};
        tbl[9]  = '{1'b0, 4'h0, 8'h00, 1'b0, 2'b01, 1'b1, 1'b0, 3'd1};
        tbl[10] = '{1'b0, 4'h0, 8'h00, 1'b1, 2'b01, 1'b1, 1'b0, 3'd1};
        tbl[11] = '{1'b0, 4'h0, 8'h00, 1'b1, 2'b01, 1'b1, 1'b0, 3'd2};
        tbl[12] = '{1'b0, 4'h0, 8'h00, 1'b0, 2'b10, 1'b1, 1'b0, 3'd2};
        tbl[13] = '{1'b0, 4'h0, 8'h00, 1'b1, 2'b10, 1'b1, 1'b0, 3'd3};
        tbl[14] = '{1'b0, 4'h0, 8'h00, 1'b0, 2'b00, 1'b1, 1'b0, 3'd3};
        tbl[15] = '{1'b0, 4'h0, 8'h00, 1'b1, 2'b00, 1'b1, 1'b0, 3'd3};
        tbl[16] = '{1'b0, 4'h0, 8'h00, 1'b0, 2'b10, 1'b0, 1'b1, 3'd3};
        tbl[17] = '{1'b0, 4'h0, 8'h00, 1'b1, 2'b10, 1'b0, 1'b1, 3'd3};

        model_reset();
        repeat (2) @(posedge xclk);
        #1;
        check("reset", 2'b10, 1'b0, 1'b0, 3'd0);
        sys_rst = 1'b1;

        for (int i = 0; i < 18; i++) begin
            cyc(tbl[i].s, tbl[i].a, tbl[i].d, tbl[i].t);
            check($sformatf("vec%0d", i), tbl[i].em, tbl[i].eb, tbl[i].ed, tbl[i].ei);
        end

        // Looping run, then clear run mid-dwell.
        cyc(1'b1, 4'h4, 8'h00, 1'b0);
        check("clear_from_done", 2'b10, 1'b0, 1'b1, 3'd3);
        cyc(1'b1, 4'h4, 8'h03, 1'b0);
        check("loop_start", 2'b10, 1'b0, 1'b0, 3'd0);
        cyc(1'b0, 4'h0, 8'h00, 1'b0);
        check("loop_e0", 2'b00, 1'b1, 1'b0, 3'd0);
        run_step(3);
        check("loop_e1", 2'b01, 1'b1, 1'b0, 3'd1);
        run_step(2);
        check("loop_e2", 2'b10, 1'b1, 1'b0, 3'd2);
        run_step(1);
        check("loop_e3", 2'b00, 1'b1, 1'b0, 3'd3);
        cyc(1'b0, 4'h0, 8'h00, 1'b1);
        check("loop_wrap", 2'b00, 1'b1, 1'b0, 3'd0);
        cyc(1'b0, 4'h0, 8'h00, 1'b0);
        cyc(1'b0, 4'h0, 8'h00, 1'b1);
        cyc(1'b1, 4'h4, 8'h00, 1'b0);
        check("clear_run_p1", 2'b00, 1'b1, 1'b0, 3'd0);
        cyc(1'b0, 4'h0, 8'h00, 1'b0);
        check("clear_run_p2", 2'b10, 1'b0, 1'b0, 3'd0);

        // Entries 1 and 2 skipped (dwell 0).
        cyc(1'b1, 4'h6, 8'h01, 1'b0);
        cyc(1'b1, 4'h7, 8'h02, 1'b0);
        cyc(1'b1, 4'h8, 8'h05, 1'b0);
        cyc(1'b1, 4'h4, 8'h01, 1'b0);
        cyc(1'b0, 4'h0, 8'h00, 1'b0);
        check("skip_e0", 2'b00, 1'b1, 1'b0, 3'd0);
        repeat (3) cyc(1'b0, 4'h0, 8'h00, 1'b1);
        check("skip_ld1", 2'b00, 1'b1, 1'b0, 3'd1);
        cyc(1'b0, 4'h0, 8'h00, 1'b0);
        check("skip_ld2", 2'b00, 1'b1, 1'b0, 3'd2);
        cyc(1'b0, 4'h0, 8'h00, 1'b0);
        check("skip_ld3", 2'b00, 1'b1, 1'b0, 3'd3);
        cyc(1'b0, 4'h0, 8'h00, 1'b0);
        check("skip_e3", 2'b01, 1'b1, 1'b0, 3'd3);
        run_step(1);
        check("skip_done", 2'b10, 1'b0, 1'b1, 3'd3);

        // All entries empty: DONE within STEPS+2 cycles of the start write.
        for (int i = 5; i <= 8; i++) cyc(1'b1, 4'(i), 8'h00, 1'b0);
        cyc(1'b1, 4'h4, 8'h00, 1'b0);
        cyc(1'b1, 4'h4, 8'h03, 1'b0);
        begin
            int k;
            k = 0;
            while (!(done === 1'b1 && busy === 1'b0) && k < 5) begin
                cyc(1'b0, 4'h0, 8'h00, 1'b0);
                k++;
            end
        end
        check("allzero_done", 2'b10, 1'b0, 1'b1, 3'd3);
        repeat (3) cyc(1'b0, 4'h0, 8'h00, 1'b1);
        check("allzero_hold", 2'b10, 1'b0, 1'b1, 3'd3);

        // Restart from DONE, coincident tick ignored, restart mid-dwell of entry 2.
        cyc(1'b1, 4'h5, 8'h0C, 1'b0);
        cyc(1'b1, 4'h6, 8'h09, 1'b0);
        cyc(1'b1, 4'h7, 8'h0A, 1'b0);
        cyc(1'b1, 4'h8, 8'h04, 1'b0);
        cyc(1'b1, 4'h4, 8'h05, 1'b0);
        check("restart_done", 2'b10, 1'b0, 1'b0, 3'd0);
        cyc(1'b0, 4'h0, 8'h00, 1'b0);
        run_step(3);
        run_step(2);
        check("rs_e2", 2'b10, 1'b1, 1'b0, 3'd2);
        cyc(1'b1, 4'h4, 8'h01, 1'b1);
        check("tick_vs_ctrl", 2'b10, 1'b1, 1'b0, 3'd2);
        cyc(1'b0, 4'h0, 8'h00, 1'b1);
        check("tick_after_ctrl", 2'b10, 1'b1, 1'b0, 3'd2);
        cyc(1'b1, 4'h4, 8'h05, 1'b0);
        check("restart_dwell", 2'b10, 1'b1, 1'b0, 3'd0);
        cyc(1'b0, 4'h0, 8'h00, 1'b0);
        check("restart_e0", 2'b00, 1'b1, 1'b0, 3'd0);

        // Asynchronous reset between clock edges.
        #2;
        sys_rst = 1'b0;
        #1;
        check("async_reset", 2'b10, 1'b0, 1'b0, 3'd0);
        model_reset();
        @(posedge xclk);
        #1;
        sys_rst = 1'b1;
        repeat (3) cyc(1'b0, 4'h0, 8'h00, 1'b1);
        check("post_reset_idle", 2'b10, 1'b0, 1'b0, 3'd0);

`ifdef LED_SCHED_READBACK_EN
        rd_subaddr = 4'h4;
        cyc(1'b0, 4'h0, 8'h00, 1'b0);
        checks++;
        if (rd_data !== 8'h00) begin
            errors++;
            $display("FAIL rd_ctrl_reset: got %h expected 00", rd_data);
        end
        cyc(1'b1, 4'h5, 8'h0C, 1'b0);
        cyc(1'b1, 4'h6, 8'h09, 1'b0);
        cyc(1'b1, 4'h4, 8'h03, 1'b0);
        cyc(1'b0, 4'h0, 8'h00, 1'b0);
        run_step(3);
        cyc(1'b0, 4'h0, 8'h00, 1'b0);
        checks++;
        if (rd_data !== 8'h47) begin
            errors++;
            $display("FAIL rd_ctrl: got %h expected 47", rd_data);
        end
        rd_subaddr = 4'h6;
        cyc(1'b0, 4'h0, 8'h00, 1'b0);
        checks++;
        if (rd_data !== 8'h09) begin
            errors++;
            $display("FAIL rd_entry1: got %h expected 09", rd_data);
        end
        rd_subaddr = 4'hC;
        cyc(1'b0, 4'h0, 8'h00, 1'b0);
        checks++;
        if (rd_data !== 8'h00) begin
            errors++;
            $display("FAIL rd_unmapped: got %h expected 00", rd_data);
        end
`endif

        // Randomized traffic against the reference model.
        for (int n = 0; n < 3000; n++) begin
            logic       s, t;
            logic [3:0] a;
            logic [7:0] d;
            int         r;
            r = int'($urandom_range(99));
            s = 1'b0; a = 4'h0; d = 8'h00;
            if (r < 4) begin
                s = 1'b1; a = 4'h4;
                d = 8'($urandom_range(255));
                d[0] = ($urandom_range(7) != 0);
                d[2] = ($urandom_range(5) == 0);
            end else if (r < 12) begin
                s = 1'b1;
                a = 4'($urandom_range(15));
                if (a == 4'h4) a = 4'h5;
                d = 8'(($urandom_range(3) << 2) | $urandom_range(3));
                if ($urandom_range(9) == 0) d[7:2] = 6'($urandom_range(63));
            end
            t = ($urandom_range(2) == 0);
            cyc(s, a, d, t);
            check_model($sformatf("rand%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_sched_ctl.md
Name: led_sched_ctl

Overview:
- Programmable LED pattern scheduler that replaces the static MiscReg mode select feeding the LED mux.
- Steps through a small table of (mode, dwell) entries. Each entry is held for "dwell" flash ticks from the flasher.
- Table and control are written over the registered I2C/Wishbone write strobe bus (XI_PWr/XI_PRWA/XI_PD).
- Output mode[1:0] uses the existing mux encoding: 00 alternating, 01 sync, 1x off.

Parameters:
- DATA_W, 8, width of write data bus (I2C data bits)
- ADDR_W, 4, width of write address bus
- STEPS, 4, number of table entries (2..8)
- BASE_ADDR, 4'h4, address of CTRL register; entries occupy BASE_ADDR+1 .. BASE_ADDR+STEPS

Ports:
- xclk, input, 1, system clock
- sys_rst, input, 1, reset; asynchronous, active-low
- wr_stb, input, 1, single-cycle write strobe (XI_PWr)
- wr_addr, input, ADDR_W, write address (XI_PRWA)
- wr_data, input, DATA_W, write data (XI_PD)
- tick, input, 1, single-cycle dwell timebase strobe (one per flash period)
- mode, output, 2, LED mode select to mux
- busy, output, 1, sequence active (LOAD or DWELL)
- done, output, 1, non-looping sequence completed
- step_idx, output, 3, index of current entry

Behaviour:
- Reset (sys_rst low, async): mode=2'b10 (off), busy=0, done=0, step_idx=0, state IDLE, CTRL=0, all entries=0.
- CTRL bits:
  - [0] run
  - [1] loop
  - [2] restart: write-only, self-clearing, reads 0
  - other bits ignored
- Entry bits: [1:0] mode, [DATA_W-1:2] dwell in ticks. Dwell 0 means skip.
- Writes complete in the wr_stb cycle. Addresses outside CTRL and the entries are ignored.
- Each entry register keeps its value once written. A change to an entry is used at its next LOAD; a running dwell is unaffected.
- FSM states:
  - IDLE: mode=off, busy=0. If run=1, go to LOAD with idx=0 and clear done.
  - LOAD (1 cycle): busy=1.
    - dwell!=0: mode<=entry.mode, cnt<=dwell, go to DWELL.
    - dwell==0: advance idx (same wrap rules as DWELL) and stay in LOAD, skip_cnt++.
    - skip_cnt reaches STEPS (all entries zero): go to DONE, no spin.
  - DWELL: busy=1. Each tick decrements cnt. A tick while cnt==1 ends the step:
    - idx<STEPS-1: idx++, go to LOAD.
    - idx==STEPS-1 and loop=1: idx=0, go to LOAD.
    - idx==STEPS-1 and loop=0: go to DONE.
    - skip_cnt clears on every non-skip LOAD.
  - DONE: mode=off, busy=0, done=1. Stays here until run is cleared (then IDLE, done stays 1) or restart is written.
- Latency: the run=1 write lands in cycle N. LOAD is in N+1, and mode/busy are valid in N+2.
- Clearing run in any state: IDLE on the next clock, mode=off in the following cycle. idx is kept in step_idx until the next start.
- restart=1 with run=1, any state: next state LOAD, idx=0, done=0. restart with run=0 has no effect.
- Simultaneous events:
  - A CTRL write in the same cycle as a tick takes priority: the tick is ignored.
  - An entry write in the same cycle as a tick: both are applied.
- A tick in IDLE, LOAD or DONE is ignored. Ticks are not queued.
- mode, busy, done and step_idx are all registered outputs.

Optional Feature:
- Macro: LED_SCHED_READBACK_EN.
- Defined:
  - Adds input rd_subaddr[ADDR_W-1:0] and output rd_data[DATA_W-1:0].
  - rd_data is registered with 1-cycle latency.
  - At CTRL, returns {busy, done, step_idx, loop, run} packed LSB-first: run [0], loop [1], step_idx [4:2], done [5], busy [6], zero-padded.
  - At entry addresses, returns the stored entry. All other addresses return 0.
  - rd_data resets to 0.
- Not defined: the ports are absent and there is no read logic.

Test Plan:
- Reset mid-DWELL (assert sys_rst between clocks, no clock edge): mode=2'b10, busy=0, step_idx=0 immediately. After release, CTRL reads 0 and the FSM stays in IDLE.
- Entries {(00,3),(01,2),(10,1),(00,1)}, loop=0, run=1: mode sequence 00×3 ticks, 01×2, 10×1, 00×1. Then done=1, busy=0, mode=off. First mode is valid 2 cycles after the write.
- Same table, loop=1: after the entry-3 tick, step_idx=0 and mode=00 again. Clear run mid-DWELL: mode=off 2 cycles after the write.
- Entries 1 and 2 with dwell=0: sequence runs entry 0, then entry 3. All entries zero with run=1: DONE within STEPS+2 cycles, busy never persists.
- restart written during DWELL of entry 2: next cycle LOAD, step_idx=0. A tick coincident with the CTRL write does not decrement.
- With LED_SCHED_READBACK_EN: read CTRL during entry 1 dwell with loop=1, run=1; rd_data=8'h47 one cycle later.
